mem_port_arbiter: RTL and testbench

Shared-memory arbiter that lets the instruction cache and the data cache take turns on a single line-wide (4-word) memory port. It sits between the two cache instances and main memory. It grants one line transaction at a time: an I-cache line fill, a D-cache line fill or a D-cache line write. It drives the memory strobes for a fixed memory latency and returns a one-cycle acknowledge to the granted cache.

---
 rtl/mem_port_arbiter_if.sv | 63 ++++++
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and main memory.
// master: the arbiter's view. slave: the view of caches plus memory.
interface mem_port_arbiter_if #(
   parameter int WORD_SIZE = 16
);
   // I-cache side
   logic                 i_req;
   logic [WORD_SIZE-1:0] i_addr;
   logic                 i_ack;

   // D-cache side
   logic                 d_req;
   logic                 d_we;
   logic [WORD_SIZE-1:0] d_addr;
   logic [WORD_SIZE-1:0] d_wdata_1;
   logic [WORD_SIZE-1:0] d_wdata_2;
   logic [WORD_SIZE-1:0] d_wdata_3;
   logic [WORD_SIZE-1:0] d_wdata_4;
   logic                 d_ack;

   // Line read data returned to whichever cache was granted
   logic [WORD_SIZE-1:0] rdata_1;
   logic [WORD_SIZE-1:0] rdata_2;
   logic [WORD_SIZE-1:0] rdata_3;
   logic [WORD_SIZE-1:0] rdata_4;

   // Memory side
   logic                 readM;
   logic                 writeM;
   logic [WORD_SIZE-1:0] mem_address;
   logic [WORD_SIZE-1:0] mem_wdata_1;
   logic [WORD_SIZE-1:0] mem_wdata_2;
   logic [WORD_SIZE-1:0] mem_wdata_3;
   logic [WORD_SIZE-1:0] mem_wdata_4;
   logic [WORD_SIZE-1:0] mem_rdata_1;
   logic [WORD_SIZE-1:0] mem_rdata_2;
   logic [WORD_SIZE-1:0] mem_rdata_3;
   logic [WORD_SIZE-1:0] mem_rdata_4;

   logic                 busy;

   modport master (
      input  i_req, i_addr,
      input  d_req, d_we, d_addr, d_wdata_1, d_wdata_2, d_wdata_3, d_wdata_4,
      input  mem_rdata_1, mem_rdata_2, mem_rdata_3, mem_rdata_4,
      output i_ack, d_ack,
      output rdata_1, rdata_2, rdata_3, rdata_4,
      output readM, writeM, mem_address,
      output mem_wdata_1, mem_wdata_2, mem_wdata_3, mem_wdata_4,
      output busy
   );

   modport slave (
      output i_req, i_addr,
      output d_req, d_we, d_addr, d_wdata_1, d_wdata_2, d_wdata_3, d_wdata_4,
      output mem_rdata_1, mem_rdata_2, mem_rdata_3, mem_rdata_4,
      input  i_ack, d_ack,
      input  rdata_1, rdata_2, rdata_3, rdata_4,
      input  readM, writeM, mem_address,
      input  mem_wdata_1, mem_wdata_2, mem_wdata_3, mem_wdata_4,
      input  busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the
// I-cache (line reads) and the D-cache (line reads and line writes).
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | arbitrate pending requests; on grant latch source/op/addr/data
//   BUSY  | memory strobe high, latency counter runs 0..MEM_LATENCY-1
//   ACK   | one-cycle ack to the granted cache, strobes low
module mem_port_arbiter #(
   parameter int WORD_SIZE   = 16,
   parameter int MEM_LATENCY = 4
) (
   input  logic               Clk,
   input  logic               Reset_N,
   mem_port_arbiter_if.master bus
);

   localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cnt;
   logic [3:0] cnt_nxt;

   // 1 = D-cache was granted last, 0 = I-cache
   logic       last_d;
   logic       last_d_nxt;

   // Latched at grant: granted source and write/read operation
   logic       src_d;
   logic       we_q;

   logic       grant_i;
   logic       grant_d;
   logic       grant;
   logic       rd_nxt;
   logic       wr_nxt;
   logic       i_ack_nxt;
   logic       d_ack_nxt;
   logic       capture;

   logic [WORD_SIZE-1:0] line_addr;

   // Line-align whichever address belongs to the winner
   always_comb begin
      line_addr = '0;
      if (grant_d) begin
         line_addr = {bus.d_addr[WORD_SIZE-1:2], 2'b00};
      end else begin
         line_addr = {bus.i_addr[WORD_SIZE-1:2], 2'b00};
      end
   end

   // State, latency counter and round-robin pointer
   always_ff @(posedge Clk) begin
      if (!Reset_N) begin
         state  <= IDLE;
         cnt    <= '0;
         last_d <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         last_d <= last_d_nxt;
      end
   end

   // Arbitration, next state and next values of the registered outputs
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      last_d_nxt = last_d;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      rd_nxt     = 1'b0;
      wr_nxt     = 1'b0;
      i_ack_nxt  = 1'b0;
      d_ack_nxt  = 1'b0;
      capture    = 1'b0;

      case (state)
         IDLE: begin
            // With both pending, the side not served last time wins
            if (bus.d_req && (!bus.i_req || !last_d)) begin
               grant_d = 1'b1;
            end else if (bus.i_req) begin
               grant_i = 1'b1;
            end
            if (grant_i || grant_d) begin
               state_nxt  = BUSY;
               cnt_nxt    = '0;
               last_d_nxt = grant_d;
               wr_nxt     = grant_d && bus.d_we;
               rd_nxt     = !(grant_d && bus.d_we);
            end
         end

         BUSY: begin
            if (cnt == CNT_LAST) begin
               state_nxt = ACK;
               cnt_nxt   = '0;
               capture   = !we_q;
               i_ack_nxt = !src_d;
               d_ack_nxt = src_d;
            end else begin
               cnt_nxt = cnt + 4'd1;
               rd_nxt  = !we_q;
               wr_nxt  = we_q;
            end
         end

         ACK: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign grant = grant_i || grant_d;

   // Registered outputs plus the per-transaction latches
   always_ff @(posedge Clk) begin
      if (!Reset_N) begin
         src_d           <= 1'b0;
         we_q            <= 1'b0;
         bus.readM       <= 1'b0;
         bus.writeM      <= 1'b0;
         bus.i_ack       <= 1'b0;
         bus.d_ack       <= 1'b0;
         bus.busy        <= 1'b0;
         bus.mem_address <= '0;
         bus.mem_wdata_1 <= '0;
         bus.mem_wdata_2 <= '0;
         bus.mem_wdata_3 <= '0;
         bus.mem_wdata_4 <= '0;
         bus.rdata_1     <= '0;
         bus.rdata_2     <= '0;
         bus.rdata_3     <= '0;
         bus.rdata_4     <= '0;
      end else begin
         bus.readM  <= rd_nxt;
         bus.writeM <= wr_nxt;
         bus.i_ack  <= i_ack_nxt;
         bus.d_ack  <= d_ack_nxt;
         bus.busy   <= (state_nxt != IDLE);

         if (grant) begin
            src_d           <= grant_d;
            we_q            <= grant_d && bus.d_we;
            bus.mem_address <= line_addr;
         end

         // Write data is only taken for D writes so it survives reads
         if (grant_d && bus.d_we) begin
            bus.mem_wdata_1 <= bus.d_wdata_1;
            bus.mem_wdata_2 <= bus.d_wdata_2;
            bus.mem_wdata_3 <= bus.d_wdata_3;
            bus.mem_wdata_4 <= bus.d_wdata_4;
         end

         if (capture) begin
            bus.rdata_1 <= bus.mem_rdata_1;
            bus.rdata_2 <= bus.mem_rdata_2;
            bus.rdata_3 <= bus.mem_rdata_3;
            bus.rdata_4 <= bus.mem_rdata_4;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: lane 0 runs MEM_LATENCY=4, lane 1 runs
// MEM_LATENCY=1. Each lane has a transaction-level model that derives the
// outputs from the number of cycles elapsed since the grant.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;
   bit mem_rand = 1'b1;

   logic [1:0]             rst_n;
   logic [1:0]             i_req;
   logic [1:0]             d_req;
   logic [1:0]             d_we;
   logic [1:0][15:0]       i_addr;
   logic [1:0][15:0]       d_addr;
   logic [1:0][3:0][15:0]  d_wdata;
   logic [1:0][3:0][15:0]  mem_rdata;

   // ctl bits: [0] readM, [1] writeM, [2] i_ack, [3] d_ack, [4] busy
   logic [1:0][4:0]        ctl_o;
   logic [1:0][15:0]       addr_o;
   logic [1:0][3:0][15:0]  rdata_o;
   logic [1:0][3:0][15:0]  wdata_o;

   logic [1:0][4:0]        e_ctl;
   logic [1:0][15:0]       e_addr;
   logic [1:0][3:0][15:0]  e_rdata;
   logic [1:0][3:0][15:0]  e_wdata;

   bit [1:0] i_seen;
   bit [1:0] d_seen;

   for (genvar g = 0; g < 2; g++) begin : g_lane
      localparam int L = (g == 0) ? 4 : 1;

      mem_port_arbiter_if #(.WORD_SIZE(16)) ifc ();

      mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(L)) dut (
         .Clk     (clk),
         .Reset_N (rst_n[g]),
         .bus     (ifc.master)
      );

      assign ifc.i_req       = i_req[g];
      assign ifc.i_addr      = i_addr[g];
      assign ifc.d_req       = d_req[g];
      assign ifc.d_we        = d_we[g];
      assign ifc.d_addr      = d_addr[g];
      assign ifc.d_wdata_1   = d_wdata[g][0];
      assign ifc.d_wdata_2   = d_wdata[g][1];
      assign ifc.d_wdata_3   = d_wdata[g][2];
      assign ifc.d_wdata_4   = d_wdata[g][3];
      assign ifc.mem_rdata_1 = mem_rdata[g][0];
      assign ifc.mem_rdata_2 = mem_rdata[g][1];
      assign ifc.mem_rdata_3 = mem_rdata[g][2];
      assign ifc.mem_rdata_4 = mem_rdata[g][3];

      assign ctl_o[g]   = {ifc.busy, ifc.d_ack, ifc.i_ack, ifc.writeM, ifc.readM};
      assign addr_o[g]  = ifc.mem_address;
      assign rdata_o[g] = {ifc.rdata_4, ifc.rdata_3, ifc.rdata_2, ifc.rdata_1};
      assign wdata_o[g] = {ifc.mem_wdata_4, ifc.mem_wdata_3, ifc.mem_wdata_2, ifc.mem_wdata_1};

      // Reference: a transaction is active for L+1 cycles after its grant;
      // the strobe covers the first L of them, the ack the last one.
      bit               act;
      bit               src_d;
      bit               we;
      bit               last_d;
      int               k;
      logic [15:0]      m_addr;
      logic [3:0][15:0] m_rd;
      logic [3:0][15:0] m_wd;
      logic             pick_d;

      assign pick_d = d_req[g] && (!i_req[g] || !last_d);

      always @(posedge clk) begin
         if (!rst_n[g]) begin
            act    <= 1'b0;
            src_d  <= 1'b0;
            we     <= 1'b0;
            last_d <= 1'b0;
            k      <= 0;
            m_addr <= '0;
            m_rd   <= '0;
            m_wd   <= '0;
         end else if (act) begin
            k <= k + 1;
            if (k == L - 1 && !we) m_rd <= mem_rdata[g];
            if (k == L) act <= 1'b0;
         end else if (i_req[g] || d_req[g]) begin
            act    <= 1'b1;
            k      <= 0;
            src_d  <= pick_d;
            last_d <= pick_d;
            we     <= pick_d && d_we[g];
            m_addr <= (pick_d ? d_addr[g] : i_addr[g]) & 16'hFFFC;
            if (pick_d && d_we[g]) m_wd <= d_wdata[g];
         end
      end

      assign e_ctl[g]   = {act, act && (k == L) && src_d, act && (k == L) && !src_d,
                           act && (k < L) && we, act && (k < L) && !we};
      assign e_addr[g]  = m_addr;
      assign e_rdata[g] = m_rd;
      assign e_wdata[g] = m_wd;
   end

   task automatic chk(input string name, input int lane, input logic [63:0] got,
                      input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s lane=%0d cyc=%0d got=%h want=%h", name, lane, cyc, got, want);
      end
   endtask

   // Every cycle: DUT outputs against the lane model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int l = 0; l < 2; l++) begin
            chk("ctl",       l, 64'(ctl_o[l]),  64'(e_ctl[l]));
            chk("mem_addr",  l, 64'(addr_o[l]), 64'(e_addr[l]));
            chk("rdata",     l, rdata_o[l],     e_rdata[l]);
            chk("mem_wdata", l, wdata_o[l],     e_wdata[l]);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      cyc++;
      if (mem_rand) mem_rdata = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Steps until the lane acks; reports latency, strobe counts and address
   task automatic wait_txn(input int lane, output int n, output bit who_d,
                           output int nrd, output int nwr, output logic [15:0] a_seen);
      bit done  = 1'b0;
      bit both  = 1'b0;
      bit moved = 1'b0;
      n = 0; who_d = 1'b0; nrd = 0; nwr = 0; a_seen = '0;
      for (int c = 1; c <= 40 && !done; c++) begin
         step();
         if (ctl_o[lane][1:0] != 2'b00) begin
            if ((nrd + nwr) > 0 && addr_o[lane] != a_seen) moved = 1'b1;
            a_seen = addr_o[lane];
         end
         nrd += int'(ctl_o[lane][0]);
         nwr += int'(ctl_o[lane][1]);
         if (ctl_o[lane][3:2] != 2'b00) begin
            done  = 1'b1;
            n     = c;
            who_d = ctl_o[lane][3];
            both  = (ctl_o[lane][3:2] == 2'b11);
         end
      end
      chk("ack_seen",      lane, 64'(done),  64'd1);
      chk("ack_exclusive", lane, 64'(both),  64'd0);
      chk("addr_stable",   lane, 64'(moved), 64'd0);
   endtask

   int          n, nrd, nwr, t_prev, busy_n, rd_n, ack_at;
   bit          who;
   bit          saw_ack;
   logic [15:0] a;
   bit [3:0]    order;

   initial begin
      rst_n = 2'b00; i_req = '0; d_req = '0; d_we = '0;
      i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      i_seen = '0; d_seen = '0;
      repeat (3) step();
      chk_en = 1'b1;
      chk("reset_ctl",   0, 64'(ctl_o), 64'd0);
      chk("reset_addr",  0, 64'(addr_o[0]), 64'd0);
      chk("reset_rdata", 0, rdata_o[0], 64'd0);
      chk("reset_wdata", 0, wdata_o[0], 64'd0);
      rst_n = 2'b11;
      step();

      // I-cache line read, fixed memory data
      mem_rand = 1'b0;
      mem_rdata[0] = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
      i_addr[0] = 16'h0013; i_req[0] = 1'b1;
      wait_txn(0, n, who, nrd, nwr, a);
      chk("t1_latency", 0, 64'(n),   64'd5);
      chk("t1_readM",   0, 64'(nrd), 64'd4);
      chk("t1_writeM",  0, 64'(nwr), 64'd0);
      chk("t1_addr",    0, 64'(a),   64'h0010);
      chk("t1_src",     0, 64'(who), 64'd0);
      chk("t1_rdata",   0, rdata_o[0], 64'h00A3_00A2_00A1_00A0);
      step(); i_req[0] = 1'b0;

      // D-cache line write
      d_addr[0] = 16'h0042; d_we[0] = 1'b1;
      d_wdata[0] = {16'd4, 16'd3, 16'd2, 16'd1}; d_req[0] = 1'b1;
      wait_txn(0, n, who, nrd, nwr, a);
      chk("t2_latency", 0, 64'(n),   64'd5);
      chk("t2_writeM",  0, 64'(nwr), 64'd4);
      chk("t2_readM",   0, 64'(nrd), 64'd0);
      chk("t2_addr",    0, 64'(a),   64'h0040);
      chk("t2_src",     0, 64'(who), 64'd1);
      chk("t2_wdata",   0, wdata_o[0], 64'h0004_0003_0002_0001);
      chk("t2_rdata",   0, rdata_o[0], 64'h00A3_00A2_00A1_00A0);
      step(); d_req[0] = 1'b0; d_we[0] = 1'b0;
      mem_rand = 1'b1;

      // Contention straight after reset: D, I, then D, I again
      rst_n[0] = 1'b0; step(); step(); rst_n[0] = 1'b1;
      for (int rep = 0; rep < 2; rep++) begin
         i_addr[0] = 16'($urandom); d_addr[0] = 16'($urandom);
         i_req[0] = 1'b1; d_req[0] = 1'b1;
         wait_txn(0, n, who, nrd, nwr, a);
         chk("t3_first_d", 0, 64'(who), 64'd1);
         step(); d_req[0] = 1'b0;
         wait_txn(0, n, who, nrd, nwr, a);
         chk("t3_second_i", 0, 64'(who), 64'd0);
         chk("t3_i_latency", 0, 64'(n), 64'd5);
         step(); i_req[0] = 1'b0;
      end

      // Both held continuously: alternate grants, L+2 cycles apart
      i_req[0] = 1'b1; d_req[0] = 1'b1;
      t_prev = 0; order = '0;
      for (int j = 0; j < 4; j++) begin
         wait_txn(0, n, who, nrd, nwr, a);
         order[j] = who;
         if (j > 0) chk("t4_spacing", 0, 64'(cyc - t_prev), 64'd6);
         t_prev = cyc;
      end
      chk("t4_order", 0, 64'(order), 64'b0101);
      step(); i_req[0] = 1'b0; d_req[0] = 1'b0;
      step();

      // Reset in the 2nd BUSY cycle abandons the read
      d_addr[0] = 16'h0080; d_we[0] = 1'b0; d_req[0] = 1'b1;
      step(); step();
      rst_n[0] = 1'b0;
      step();
      chk("t5_rst_ctl", 0, 64'(ctl_o[0]), 64'd0);
      step();
      chk("t5_rst_hold", 0, 64'(ctl_o[0]), 64'd0);
      rst_n[0] = 1'b1; i_req[0] = 1'b1; i_addr[0] = 16'h0104;
      wait_txn(0, n, who, nrd, nwr, a);
      chk("t5_d_first", 0, 64'(who), 64'd1);
      chk("t5_addr",    0, 64'(a),   64'h0080);
      step(); d_req[0] = 1'b0;
      wait_txn(0, n, who, nrd, nwr, a);
      chk("t5_then_i", 0, 64'(who), 64'd0);
      step(); i_req[0] = 1'b0;

      // Minimum latency lane
      i_addr[1] = 16'h0207; i_req[1] = 1'b1;
      busy_n = 0; rd_n = 0; ack_at = 0; saw_ack = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         step();
         if (saw_ack) i_req[1] = 1'b0;
         busy_n += int'(ctl_o[1][4]);
         rd_n   += int'(ctl_o[1][0]);
         saw_ack = ctl_o[1][2];
         if (saw_ack) ack_at = c;
      end
      chk("t6_busy_cycles", 1, 64'(busy_n), 64'd2);
      chk("t6_readM",       1, 64'(rd_n),   64'd1);
      chk("t6_ack_at",      1, 64'(ack_at), 64'd2);
      chk("t6_addr",        1, 64'(addr_o[1]), 64'h0204);

      // Random traffic on both lanes, occasional resets
      for (int c = 0; c < 3000; c++) begin
         step();
         for (int l = 0; l < 2; l++) begin
            rst_n[l] = ($urandom_range(0, 399) != 0);
            d_wdata[l] = {$urandom, $urandom};
            if (i_seen[l]) begin
               i_seen[l] = 1'b0;
               if ($urandom_range(0, 3) == 0) i_addr[l] = 16'($urandom);
               else i_req[l] = 1'b0;
            end else if (i_req[l]) begin
               i_seen[l] = ctl_o[l][2];
            end else if ($urandom_range(0, 2) == 0) begin
               i_req[l] = 1'b1; i_addr[l] = 16'($urandom);
            end
            if (d_seen[l]) begin
               d_seen[l] = 1'b0;
               if ($urandom_range(0, 3) == 0) begin
                  d_addr[l] = 16'($urandom); d_we[l] = 1'($urandom);
               end else begin
                  d_req[l] = 1'b0;
               end
            end else if (d_req[l]) begin
               d_seen[l] = ctl_o[l][3];
            end else if ($urandom_range(0, 2) == 0) begin
               d_req[l] = 1'b1; d_addr[l] = 16'($urandom); d_we[l] = 1'($urandom);
            end
         end
      end

      step();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
